// File: rtl/pdp8_bus_pkg.sv
// Definitions shared by the bus strobe sequencer and the blocks around it.
package pdp8_bus_pkg;

  // Width of the shared PDP-8 data bus.
  localparam int BUS_W    = 12;
  // Default number of bus sources and destination latches.
  localparam int NSRC_DEF = 8;
  localparam int NDST_DEF = 8;

  // Phases of one register transfer.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    CAPTURE = 2'd2,
    RELEASE = 2'd3
  } seq_state_t;

  // Larger of two integers. Used to size the phase timer.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/strobe_timer.sv
// Loadable down-counter that times the DRIVE and CAPTURE phases.
// The count stops at zero, and zero is flagged combinationally from the count register.
module strobe_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] count;

  // Counts down from the loaded value and holds at zero.
  // NOTE: clocked state uses non-blocking assignment so that every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/bus_strobe_sequencer.sv
// Initiator side of the latch/output-enable protocol.
// It drives one source onto the shared bus and gives one destination latch a clean rising edge
// while the bus is stable. All outputs are registered, so no input reaches an output combinationally.
module bus_strobe_sequencer
  import pdp8_bus_pkg::*;
#(
  parameter int NSRC    = NSRC_DEF,
  parameter int NDST    = NDST_DEF,
  parameter int SETTLE  = 1,
  parameter int LATCH_W = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req,
  input  logic [$clog2(NSRC)-1:0] src,
  input  logic                    src_en,
  input  logic [$clog2(NDST)-1:0] dst,
  output logic [NSRC-1:0]         oe,
  output logic [NDST-1:0]         latch,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int SW = $clog2(NSRC);
  localparam int DW = $clog2(NDST);
  localparam int CW = $clog2(max2(SETTLE, LATCH_W) + 1);

  seq_state_t state, next_state;

  logic [SW-1:0] src_q, src_n;
  logic [DW-1:0] dst_q, dst_n;
  logic          en_q, en_n;

  logic          bad_req;
  logic          accept;
  logic          reject;
  logic          tmr_load;
  logic [CW-1:0] tmr_value;
  logic          tmr_zero;

  logic [NSRC-1:0] oe_n;
  logic [NDST-1:0] latch_n;
  logic            busy_n;
  logic            done_n;
  logic            err_n;

  strobe_timer #(.W(CW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (tmr_load),
    .value (tmr_value),
    .zero  (tmr_zero)
  );

  // A request is illegal if it names a source or destination line that does not exist.
  // A clear transfer (src_en=0) ignores src.
  assign bad_req = (src_en && (int'(src) >= NSRC)) || (int'(dst) >= NDST);

  // Phase register. Reset abandons any transfer in progress.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Latches the transfer indices when a request is accepted. They are held until IDLE is re-entered.
  // NOTE: these registers are not reset because they are only read after a load.
  always_ff @(posedge clk) begin
    if (accept) begin
      src_q <= src;
      dst_q <= dst;
      en_q  <= src_en;
    end
  end

  // Next-phase logic. The timer is reloaded on entry to each timed phase.
  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    reject     = 1'b0;
    tmr_load   = 1'b0;
    tmr_value  = '0;
    case (state)
      IDLE: begin
        if (req) begin
          if (bad_req) begin
            reject = 1'b1;
          end else begin
            accept     = 1'b1;
            next_state = DRIVE;
            tmr_load   = 1'b1;
            tmr_value  = CW'(SETTLE - 1);
          end
        end
      end
      DRIVE: begin
        if (tmr_zero) begin
          next_state = CAPTURE;
          tmr_load   = 1'b1;
          tmr_value  = CW'(LATCH_W - 1);
        end
      end
      CAPTURE: begin
        if (tmr_zero) next_state = RELEASE;
      end
      RELEASE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Strobe values for the coming phase. On acceptance they are decoded from the
  // live inputs, because the captured indices are still being loaded.
  always_comb begin
    src_n   = accept ? src    : src_q;
    dst_n   = accept ? dst    : dst_q;
    en_n    = accept ? src_en : en_q;
    oe_n    = '0;
    latch_n = '0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    err_n   = reject;
    case (next_state)
      DRIVE: begin
        busy_n = 1'b1;
        if (en_n) oe_n[src_n] = 1'b1;
      end
      CAPTURE: begin
        busy_n         = 1'b1;
        latch_n[dst_n] = 1'b1;
        if (en_n) oe_n[src_n] = 1'b1;
      end
      RELEASE: begin
        busy_n = 1'b1;
        done_n = 1'b1;
        if (en_n) oe_n[src_n] = 1'b1;
      end
      default: ;
    endcase
  end

  // Output registers. These remove any combinational path from the inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      oe    <= '0;
      latch <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      oe    <= oe_n;
      latch <= latch_n;
      busy  <= busy_n;
      done  <= done_n;
      err   <= err_n;
    end
  end

endmodule

// File: tb/tb_bus_strobe_sequencer.sv
// Self-checking bench for bus_strobe_sequencer. Three configurations share one stimulus:
//   a: NSRC=8 SETTLE=2 LATCH_W=1
//   b: NSRC=8 SETTLE=1 LATCH_W=2
//   c: NSRC=6 SETTLE=2 LATCH_W=1
// A per-instance scoreboard queue holds the expected output on every cycle.
module tb_bus_strobe_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       req;
  logic       src_en;
  logic [2:0] src;
  logic [2:0] dst;

  logic [7:0] oe_a, latch_a, oe_b, latch_b, latch_c;
  logic [5:0] oe_c;
  logic       busy_a, done_a, err_a;
  logic       busy_b, done_b, err_b;
  logic       busy_c, done_c, err_c;

  always #5 clk = ~clk;

  bus_strobe_sequencer #(.NSRC(8), .NDST(8), .SETTLE(2), .LATCH_W(1)) dut_a (
    .clk(clk), .reset(reset), .req(req), .src(src), .src_en(src_en), .dst(dst),
    .oe(oe_a), .latch(latch_a), .busy(busy_a), .done(done_a), .err(err_a));

  bus_strobe_sequencer #(.NSRC(8), .NDST(8), .SETTLE(1), .LATCH_W(2)) dut_b (
    .clk(clk), .reset(reset), .req(req), .src(src), .src_en(src_en), .dst(dst),
    .oe(oe_b), .latch(latch_b), .busy(busy_b), .done(done_b), .err(err_b));

  bus_strobe_sequencer #(.NSRC(6), .NDST(8), .SETTLE(2), .LATCH_W(1)) dut_c (
    .clk(clk), .reset(reset), .req(req), .src(src), .src_en(src_en), .dst(dst),
    .oe(oe_c), .latch(latch_c), .busy(busy_c), .done(done_c), .err(err_c));

  typedef struct packed {
    logic [7:0] oe;
    logic [7:0] latch;
    logic       busy;
    logic       done;
    logic       err;
  } exp_t;

  exp_t sb[3][$];
  int   total = 0;
  int   bad   = 0;
  bit   checking = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected per-cycle outputs for one request accepted (or refused) by instance k.
  function automatic void plan(input int k);
    int         settle, lw, nsrc;
    exp_t       r;
    logic [7:0] o;
    settle = (k == 1) ? 1 : 2;
    lw     = (k == 1) ? 2 : 1;
    nsrc   = (k == 2) ? 6 : 8;
    r = '0;
    if (src_en && int'(src) >= nsrc) begin
      r.err = 1'b1;
      sb[k].push_back(r);
      return;
    end
    o = src_en ? (8'h01 << src) : 8'h00;
    r.busy = 1'b1;
    r.oe   = o;
    repeat (settle) sb[k].push_back(r);
    r.latch = 8'h01 << dst;
    repeat (lw) sb[k].push_back(r);
    r.latch = 8'h00;
    r.done  = 1'b1;
    sb[k].push_back(r);
    r = '0;
    sb[k].push_back(r);   // mandatory IDLE cycle before the next request can be taken
  endfunction

  function automatic exp_t actual(input int k);
    exp_t r;
    if (k == 0) begin
      r.oe = oe_a; r.latch = latch_a; r.busy = busy_a; r.done = done_a; r.err = err_a;
    end else if (k == 1) begin
      r.oe = oe_b; r.latch = latch_b; r.busy = busy_b; r.done = done_b; r.err = err_b;
    end else begin
      r.oe = {2'b00, oe_c}; r.latch = latch_c; r.busy = busy_c; r.done = done_c; r.err = err_c;
    end
    return r;
  endfunction

  // Reference model: when an instance is idle, it takes a request on the clock edge.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (reset) sb[k].delete();
      else if (sb[k].size() == 0 && req) plan(k);
    end
  end

  // On every falling edge, each instance is compared against its scoreboard. An empty queue means all outputs are 0.
  always @(negedge clk) begin
    if (checking) begin
      for (int k = 0; k < 3; k++) begin
        exp_t e;
        exp_t a;
        e = '0;
        if (sb[k].size() > 0) e = sb[k].pop_front();
        a = actual(k);
        check($sformatf("sb_dut%0d", k), 32'(a), 32'(e));
      end
    end
  end

  typedef struct {
    logic [2:0] src;
    logic       en;
    logic [2:0] dst;
    logic [7:0] oe_a;      // dut_a oe during CAPTURE (cycle 3)
    logic [7:0] latch_a;   // dut_a latch during CAPTURE (cycle 3)
    logic       err_c;     // dut_c err on cycle 1
  } vec_t;

  vec_t        vecs[7];
  logic [17:0] basic_exp[1:5];
  logic [8:0]  b2b_pat;
  bit          got;

  initial begin
    vecs[0] = '{3'd3, 1'b1, 3'd5, 8'h08, 8'h20, 1'b0};
    vecs[1] = '{3'd0, 1'b1, 3'd7, 8'h01, 8'h80, 1'b0};
    vecs[2] = '{3'd7, 1'b1, 3'd1, 8'h80, 8'h02, 1'b1};
    vecs[3] = '{3'd6, 1'b1, 3'd3, 8'h40, 8'h08, 1'b1};
    vecs[4] = '{3'd0, 1'b0, 3'd0, 8'h00, 8'h01, 1'b0};
    vecs[5] = '{3'd7, 1'b0, 3'd6, 8'h00, 8'h40, 1'b0};
    vecs[6] = '{3'd5, 1'b1, 3'd2, 8'h20, 8'h04, 1'b0};

    // Basic transfer on dut_a (src=3, dst=5). Each entry is {oe, latch, busy, done}.
    basic_exp[1] = {8'h08, 8'h00, 1'b1, 1'b0};
    basic_exp[2] = {8'h08, 8'h00, 1'b1, 1'b0};
    basic_exp[3] = {8'h08, 8'h20, 1'b1, 1'b0};
    basic_exp[4] = {8'h08, 8'h00, 1'b1, 1'b1};
    basic_exp[5] = {8'h00, 8'h00, 1'b0, 1'b0};

    // Bit c-1 gives dut_b latch[2] on cycle c when req is held high.
    b2b_pat = 9'b011000110;

    reset = 1'b1; req = 1'b0; src = '0; dst = '0; src_en = 1'b1;
    repeat (2) @(negedge clk);
    checking = 1'b1;
    @(negedge clk);
    check("reset_state_a", {oe_a, latch_a, busy_a, done_a, err_a}, '0);
    reset = 1'b0;
    @(negedge clk);

    // Table-driven single transfers
    for (int i = 0; i < 7; i++) begin
      src = vecs[i].src; src_en = vecs[i].en; dst = vecs[i].dst; req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      check($sformatf("vec%0d_err_c", i), 32'(err_c), 32'(vecs[i].err_c));
      repeat (2) @(negedge clk);
      check($sformatf("vec%0d_oe_a", i), 32'(oe_a), 32'(vecs[i].oe_a));
      check($sformatf("vec%0d_latch_a", i), 32'(latch_a), 32'(vecs[i].latch_a));
      repeat (3) @(negedge clk);
    end

    // Basic transfer, checked cycle by cycle
    src = 3'd3; dst = 3'd5; src_en = 1'b1; req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) req = 1'b0;
      check($sformatf("basic_c%0d", c), {oe_a, latch_a, busy_a, done_a}, basic_exp[c]);
    end
    @(negedge clk);

    // Back-to-back transfers with req held high
    src = 3'd1; dst = 3'd2; src_en = 1'b1; req = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      check($sformatf("b2b_latch2_c%0d", c), 32'(latch_b[2]), 32'(b2b_pat[c-1]));
    end
    req = 1'b0;
    repeat (4) @(negedge clk);

    // Changes to src, dst and req during a transfer are ignored
    src = 3'd1; dst = 3'd4; src_en = 1'b1; req = 1'b1;
    @(negedge clk);
    req = 1'b0; src = 3'd6; dst = 3'd0;
    repeat (2) @(negedge clk);
    check("busy_keep_oe_a", 32'(oe_a), 32'h02);
    check("busy_keep_latch_a", 32'(latch_a), 32'h10);
    req = 1'b1; src = 3'd2; dst = 3'd3;
    @(negedge clk);
    req = 1'b0;
    check("busy_done_a", 32'(done_a), 32'h1);
    repeat (6) @(negedge clk);

    // Reset asserted during CAPTURE
    src = 3'd4; dst = 3'd1; src_en = 1'b1; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid_a", {oe_a, latch_a, busy_a, done_a}, '0);
    check("reset_mid_b", {oe_b, latch_b, busy_b, done_b}, '0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    src = 3'd2; dst = 3'd6; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      if (done_a) got = 1'b1;
      else @(negedge clk);
    end
    check("reset_recover_done_a", 32'(got), 32'h1);

    repeat (6) @(negedge clk);
    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
